// File: rtl/instr_decode_queue_pkg.sv
// Shared RV32I decode types, opcode constants and the pure decode function
// used by the buffered decode stage.
package instr_decode_queue_pkg;

    typedef logic [31:0] raw_instr_t;
    typedef logic [4:0]  regId_t;

    typedef enum logic [2:0] {
        instr_type_R,
        instr_type_I,
        instr_type_S,
        instr_type_SB,
        instr_type_U,
        instr_type_UJ
    } instr_type_t;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [6:0]  opcode;
        regId_t      rd;
        regId_t      rs1;
        regId_t      rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } decoded_instr_x_t;

    typedef struct packed {
        decoded_instr_x_t dec;
        instr_type_t      itype;
        logic             illegal;
    } decode_result_t;

    function automatic decode_result_t decode_rv32(input raw_instr_t instr);
        decode_result_t r;
        // NOTE: start from all-zero so every path assigns every field; undefined fields read 0 and no path leaves state implied.
        r            = '0;
        r.itype      = instr_type_R;
        r.dec.opcode = instr[6:0];
        case (instr[6:0])
            OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_JALR, OP_SYSTEM: begin
                r.itype      = instr_type_I;
                r.dec.rd     = instr[11:7];
                r.dec.rs1    = instr[19:15];
                r.dec.funct3 = instr[14:12];
                r.dec.imm    = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                r.itype      = instr_type_S;
                r.dec.rs1    = instr[19:15];
                r.dec.rs2    = instr[24:20];
                r.dec.funct3 = instr[14:12];
                r.dec.imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                r.itype      = instr_type_SB;
                r.dec.rs1    = instr[19:15];
                r.dec.rs2    = instr[24:20];
                r.dec.funct3 = instr[14:12];
                r.dec.imm    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_AUIPC, OP_LUI: begin
                r.itype   = instr_type_U;
                r.dec.rd  = instr[11:7];
                r.dec.imm = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                r.itype   = instr_type_UJ;
                r.dec.rd  = instr[11:7];
                r.dec.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_OP: begin
                r.dec.rd     = instr[11:7];
                r.dec.rs1    = instr[19:15];
                r.dec.rs2    = instr[24:20];
                r.dec.funct3 = instr[14:12];
                r.dec.funct7 = instr[31:25];
            end
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_decode_queue_fifo.sv
// Synchronous FIFO with flush and occupancy count; pointers wrap naturally
// at DEPTH (power of two).
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Buffered RV32I decode stage: fetch pushes raw instructions into a FIFO, the
// head is decoded combinationally and captured in a registered output stage.
module instr_decode_queue
    import instr_decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output decoded_instr_x_t       out_dec,
    output instr_type_t            out_type,
    output logic                   out_illegal,
    output logic [PC_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int ENTRY_W = 32 + PC_W;

    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               load;
    decode_result_t     head_dec;

    // A full FIFO refuses input even when the output stage drains this cycle.
    assign in_ready = !flush_i && !fifo_full;
    assign push     = in_valid && in_ready;
    assign load     = !fifo_empty && (!out_valid || out_ready) && !flush_i;
    assign head_dec = decode_rv32(head[31:0]);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (push),
        .pop   (load),
        .wdata ({in_pc, in_instr}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_dec     <= '0;
            out_type    <= instr_type_R;
            out_illegal <= 1'b0;
            out_pc      <= '0;
        end else if (flush_i) begin
            out_valid   <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_dec     <= head_dec.dec;
            out_type    <= head_dec.itype;
            out_illegal <= head_dec.illegal;
            out_pc      <= head[ENTRY_W-1:32];
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    stall_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush_i) |=> (out_valid && $stable(out_dec) &&
        $stable(out_type) && $stable(out_illegal) && $stable(out_pc)));

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: a reference decoder predicts each
// accepted instruction, predictions are compared as the consumer takes outputs.
module tb_instr_decode_queue;
    import instr_decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    typedef struct {
        decoded_instr_x_t dec;
        instr_type_t      itype;
        logic             illegal;
        logic [PC_W-1:0]  pc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush_i;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_instr;
    logic [PC_W-1:0]        in_pc;
    logic                   out_valid;
    logic                   out_ready;
    decoded_instr_x_t       out_dec;
    instr_type_t            out_type;
    logic                   out_illegal;
    logic [PC_W-1:0]        out_pc;
    logic [$clog2(DEPTH):0] count_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h67, 7'h33, 7'h73, 7'h0F, 7'h2B};

    always #5 clk = ~clk;

    instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dec    (out_dec),
        .out_type   (out_type),
        .out_illegal(out_illegal),
        .out_pc     (out_pc),
        .count_o    (count_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decoder, written field-by-field from the ISA immediate layouts.
    function automatic exp_t model(input logic [31:0] w, input logic [PC_W-1:0] pc);
        exp_t e;
        e.dec        = '0;
        e.dec.opcode = w[6:0];
        e.itype      = instr_type_R;
        e.illegal    = 1'b0;
        e.pc         = pc;
        case (w[6:0])
            7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: begin
                e.itype = instr_type_I;
                e.dec.rd = w[11:7]; e.dec.rs1 = w[19:15]; e.dec.funct3 = w[14:12];
                e.dec.imm = {{20{w[31]}}, w[31:20]};
            end
            7'h23: begin
                e.itype = instr_type_S;
                e.dec.rs1 = w[19:15]; e.dec.rs2 = w[24:20]; e.dec.funct3 = w[14:12];
                e.dec.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'h63: begin
                e.itype = instr_type_SB;
                e.dec.rs1 = w[19:15]; e.dec.rs2 = w[24:20]; e.dec.funct3 = w[14:12];
                e.dec.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h17, 7'h37: begin
                e.itype = instr_type_U;
                e.dec.rd = w[11:7];
                e.dec.imm = {w[31:12], 12'h000};
            end
            7'h6F: begin
                e.itype = instr_type_UJ;
                e.dec.rd = w[11:7];
                e.dec.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h33: begin
                e.dec.rd = w[11:7]; e.dec.rs1 = w[19:15]; e.dec.rs2 = w[24:20];
                e.dec.funct3 = w[14:12]; e.dec.funct7 = w[31:25];
            end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor: handshakes are sampled mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush_i) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", {32'h0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_dec", out_dec, e.dec);
                    check("sb_type", out_type, e.itype);
                    check("sb_illegal", out_illegal, e.illegal);
                    check("sb_pc", out_pc, e.pc);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
        end
    end

    task automatic send(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        int guard = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [PC_W-1:0] base;
        exp_t e;

        rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count_o, 0);
        check("rst_out_dec", out_dec, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_out_type", out_type, instr_type_R);
        rst = 1'b0;
        step();

        // Latency and addi decode
        send(32'h0050_0093, 32'h100);
        check("lat_not_yet_valid", out_valid, 0);
        step();
        check("lat_valid", out_valid, 1);
        check("addi_type", out_type, instr_type_I);
        check("addi_rd", out_dec.rd, 1);
        check("addi_rs1", out_dec.rs1, 0);
        check("addi_imm", out_dec.imm, 32'h0000_0005);
        check("addi_pc", out_pc, 32'h100);
        check("addi_illegal", out_illegal, 0);

        send(32'hFE00_0EE3, 32'h104);
        step();
        check("beq_type", out_type, instr_type_SB);
        check("beq_imm", out_dec.imm, 32'hFFFF_FFFC);
        send(32'h8000_00EF, 32'h108);
        step();
        check("jal_type", out_type, instr_type_UJ);
        check("jal_imm", out_dec.imm, 32'hFFF0_0000);
        step();

        // Stall: output held, FIFO fills to DEPTH
        out_ready = 1'b0;
        base = 32'h3000;
        for (int i = 0; i <= DEPTH; i++)
            send({20'(i * 1234 + 7), 5'(i + 1), 7'h37}, base + PC_W'(4 * i));
        e = model({20'd7, 5'd1, 7'h37}, base);
        check("stall_count_full", count_o, DEPTH);
        check("stall_in_ready", in_ready, 0);
        in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'hBAD0;
        step(); step();
        in_valid = 1'b0;
        check("stall_count_hold", count_o, DEPTH);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_pc", out_pc, base);
        check("stall_out_dec", out_dec, e.dec);
        out_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            check("drain_valid", out_valid, 1);
            check("drain_pc", out_pc, base + PC_W'(4 * i));
            step();
        end
        check("drain_done", out_valid, 0);

        // Back-to-back traffic with pointer wrap
        base = 32'h2000;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            w = $urandom();
            w[6:0] = ops[i % 12];
            in_valid = 1'b1; in_instr = w; in_pc = base + PC_W'(4 * i);
            step();
            check("b2b_count_le1", count_o <= 1, 1);
            if (i > 0) begin
                check("b2b_no_bubble", out_valid, 1);
                check("b2b_pc", out_pc, base + PC_W'(4 * (i - 1)));
            end
        end
        in_valid = 1'b0;
        step();
        check("b2b_last_pc", out_pc, base + PC_W'(4 * (3 * DEPTH - 1)));
        step();

        // Flush with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send({12'(i + 1), 5'd0, 3'b000, 5'd3, 7'h13}, 32'h4000 + PC_W'(4 * i));
        check("flush_pre_count", count_o, 3);
        flush_i = 1'b1; in_valid = 1'b1; in_instr = 32'h00A0_0113; in_pc = 32'hDEAD0;
        step();
        flush_i = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_count", count_o, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_nothing_emerges", out_valid, 0);
        end

        // Illegal opcodes
        send(32'h0000_007F, 32'h5000);
        step();
        check("ill7f_flag", out_illegal, 1);
        check("ill7f_imm", out_dec.imm, 0);
        check("ill7f_opcode", out_dec.opcode, 7'h7F);
        check("ill7f_type", out_type, instr_type_R);
        send(32'h0000_0000, 32'h5004);
        step();
        check("ill00_flag", out_illegal, 1);
        check("ill00_imm", out_dec.imm, 0);
        step();

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'h0050_0093, 32'h6000);
        send(32'h8000_00EF, 32'h6004);
        check("rstmid_pre_count", count_o, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_count", count_o, 0);
        check("rstmid_out_pc", out_pc, 0);
        check("rstmid_out_dec", out_dec, 0);
        check("rstmid_illegal", out_illegal, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid_no_stale", out_valid, 0);
        end

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
